fan_pwm: RTL and testbench

//  PWM generator for the fan whose tachometer the tacho block measures; sits

---
 rtl/fan_pwm.sv | 116 +++++++++++
 tb/tb_fan_pwm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm.sv
// rtl/fan_pwm.sv - Fan PWM generator with double-buffered duty and period scale
module fan_pwm #(
   parameter logic [4:0] BASE_ADDR = 5'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   input  logic       pwm_ce,
   output logic       pwm_out
);

   localparam logic [4:0] CTRL_ADDR = BASE_ADDR;
   localparam logic [4:0] DUTY_ADDR = BASE_ADDR + 5'd1;

   // Programmed (CPU-visible) registers
   logic       en_q, en_d;
   logic [1:0] scale_q, scale_d;
   logic [6:0] duty_q, duty_d;

   // Active (shadow) copies used by the counter and comparator
   logic [1:0] scale_act_q, scale_act_d;
   logic [6:0] duty_act_q, duty_act_d;

   logic [6:0] cnt_q, cnt_d;
   logic       pwm_q, pwm_d;

   logic [6:0] period_last;
   logic       period_end;

   // CSR write decode into the programmed registers
   always_comb begin
      en_d    = en_q;
      scale_d = scale_q;
      duty_d  = duty_q;
      if (csr_we && (csr_a == CTRL_ADDR)) begin
         en_d    = csr_di[7];
         scale_d = csr_di[1:0];
      end
      if (csr_we && (csr_a == DUTY_ADDR)) begin
         duty_d = csr_di[6:0];
      end
   end

   // CSR read mux; reads show programmed values, never the shadows
   always_comb begin
      csr_do = 8'h00;
      if (csr_a == CTRL_ADDR) begin
         csr_do = {en_q, 5'b0, scale_q};
      end else if (csr_a == DUTY_ADDR) begin
         csr_do = {1'b0, duty_q};
      end
   end

   // Last count of the active period: 127, 63, 31 or 15. Using the active
   // scale guarantees a shorter programmed period never truncates this one.
   always_comb begin
      period_last = 7'h7F >> scale_act_q;
      period_end  = (cnt_q == period_last);
   end

   // Counter and shadow load. While disabled the shadows follow the
   // next-register values so that an enable in the same write as a scale
   // change starts with that scale. While enabled they reload only at the
   // wrap, from the pre-write register values, so a write landing on the
   // wrap cycle waits for the following boundary.
   always_comb begin
      cnt_d       = cnt_q;
      scale_act_d = scale_act_q;
      duty_act_d  = duty_act_q;
      if (!en_q) begin
         cnt_d       = 7'd0;
         scale_act_d = scale_d;
         duty_act_d  = duty_d;
      end else if (pwm_ce) begin
         if (period_end) begin
            cnt_d       = 7'd0;
            scale_act_d = scale_q;
            duty_act_d  = duty_q;
         end else begin
            cnt_d = cnt_q + 7'd1;
         end
      end
   end

   // Output compare; duty at or above the period length clamps high
   always_comb begin
      pwm_d = en_q & (cnt_q < duty_act_q);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q        <= 1'b0;
         scale_q     <= 2'd0;
         duty_q      <= 7'd0;
         scale_act_q <= 2'd0;
         duty_act_q  <= 7'd0;
         cnt_q       <= 7'd0;
         pwm_q       <= 1'b0;
      end else begin
         en_q        <= en_d;
         scale_q     <= scale_d;
         duty_q      <= duty_d;
         scale_act_q <= scale_act_d;
         duty_act_q  <= duty_act_d;
         cnt_q       <= cnt_d;
         pwm_q       <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_fan_pwm.sv
// tb/tb_fan_pwm.sv - Directed self-checking bench for fan_pwm
module tb_fan_pwm;

   localparam logic [4:0] CTRL_A = 5'd0;
   localparam logic [4:0] DUTY_A = 5'd1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] csr_a = 5'd0;
   logic [7:0] csr_di = 8'd0;
   logic       csr_we = 1'b0;
   logic [7:0] csr_do;
   logic       pwm_ce = 1'b0;
   logic       pwm_out;

   int checks = 0;
   int errors = 0;

   fan_pwm #(.BASE_ADDR(5'h0)) dut (
      .clk     (clk),
      .rst     (rst),
      .csr_a   (csr_a),
      .csr_di  (csr_di),
      .csr_we  (csr_we),
      .csr_do  (csr_do),
      .pwm_ce  (pwm_ce),
      .pwm_out (pwm_out)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      tick();
      csr_we = 1'b0;
   endtask

   task automatic csr_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
      csr_a = a;
      #1;
      chk(tag, csr_do, exp);
   endtask

   task automatic expect_pwm(input string tag, input int n, input logic v);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, {7'b0, pwm_out}, {7'b0, v});
      end
   endtask

   // Directed sequence
   initial begin
      // Reset state
      tick();
      tick();
      chk("reset_pwm", {7'b0, pwm_out}, 8'h00);
      csr_check("reset_ctrl", CTRL_A, 8'h00);
      csr_check("reset_duty", DUTY_A, 8'h00);
      rst = 1'b0;
      pwm_ce = 1'b1;
      expect_pwm("disabled_after_reset", 4, 1'b0);

      // Basic duty: 32 high, 96 low
      csr_write(DUTY_A, 8'd32);
      csr_write(CTRL_A, 8'h80);
      chk("enable_edge", {7'b0, pwm_out}, 8'h00);
      expect_pwm("basic_hi1", 32, 1'b1);
      expect_pwm("basic_lo1", 96, 1'b0);
      expect_pwm("basic_hi2", 32, 1'b1);
      expect_pwm("basic_lo2", 96, 1'b0);

      // Disable mid high phase
      expect_pwm("pre_disable_hi", 5, 1'b1);
      csr_write(CTRL_A, 8'h00);
      expect_pwm("disable_next_clk", 1, 1'b0);
      expect_pwm("disabled_low", 20, 1'b0);

      // Scale 3: 16-tick period, 4 high
      csr_write(DUTY_A, 8'd4);
      csr_write(CTRL_A, 8'h83);
      chk("scale_enable_edge", {7'b0, pwm_out}, 8'h00);
      csr_check("ctrl_read_83", CTRL_A, 8'h83);
      expect_pwm("scale_hi1", 4, 1'b1);
      expect_pwm("scale_lo1", 12, 1'b0);
      expect_pwm("scale_hi2", 4, 1'b1);
      expect_pwm("scale_lo2", 12, 1'b0);
      // DUTY=100 >= 16 clamps high from the next period
      csr_write(DUTY_A, 8'd100);
      chk("clamp_write_cycle", {7'b0, pwm_out}, 8'h01);
      expect_pwm("clamp_old_hi", 3, 1'b1);
      expect_pwm("clamp_old_lo", 12, 1'b0);
      expect_pwm("clamp_high", 48, 1'b1);

      // Boundary update: DUTY_act=64, write 10 mid-period
      csr_write(CTRL_A, 8'h00);
      tick();
      csr_write(DUTY_A, 8'd64);
      csr_write(CTRL_A, 8'h80);
      chk("b64_enable_edge", {7'b0, pwm_out}, 8'h00);
      expect_pwm("b64_pre_write", 5, 1'b1);
      csr_write(DUTY_A, 8'd10);
      chk("b64_write_cycle", {7'b0, pwm_out}, 8'h01);
      expect_pwm("b64_keeps_hi", 58, 1'b1);
      expect_pwm("b64_lo", 64, 1'b0);
      expect_pwm("b10_hi", 10, 1'b1);
      expect_pwm("b10_lo", 118, 1'b0);
      // Write landing on the wrap cycle is delayed one more period
      expect_pwm("b10_hi_b", 10, 1'b1);
      expect_pwm("b10_lo_b", 117, 1'b0);
      csr_write(DUTY_A, 8'd50);
      chk("wrap_write_cycle", {7'b0, pwm_out}, 8'h00);
      csr_check("duty_read_50", DUTY_A, 8'd50);
      expect_pwm("wrap_delay_hi", 10, 1'b1);
      expect_pwm("wrap_delay_lo", 118, 1'b0);
      expect_pwm("b50_hi", 50, 1'b1);
      expect_pwm("b50_lo", 78, 1'b0);

      // Enable with DUTY=0 stays low
      csr_write(CTRL_A, 8'h00);
      tick();
      csr_write(DUTY_A, 8'd0);
      csr_write(CTRL_A, 8'h80);
      expect_pwm("duty0_low", 140, 1'b0);

      // Counter holds without pwm_ce
      csr_write(CTRL_A, 8'h00);
      tick();
      csr_write(DUTY_A, 8'd3);
      pwm_ce = 1'b0;
      csr_write(CTRL_A, 8'h80);
      chk("ce_enable_edge", {7'b0, pwm_out}, 8'h00);
      expect_pwm("ce_hold_hi", 20, 1'b1);
      pwm_ce = 1'b1;
      expect_pwm("ce_p1", 1, 1'b1);
      pwm_ce = 1'b0;
      expect_pwm("ce_g1", 1, 1'b1);
      pwm_ce = 1'b1;
      expect_pwm("ce_p2", 1, 1'b1);
      pwm_ce = 1'b0;
      expect_pwm("ce_g2", 1, 1'b1);
      pwm_ce = 1'b1;
      expect_pwm("ce_p3", 1, 1'b1);
      pwm_ce = 1'b0;
      expect_pwm("ce_g3", 1, 1'b0);
      expect_pwm("ce_hold_lo", 10, 1'b0);

      // CSR decode
      csr_check("undecoded_read", 5'd2, 8'h00);
      csr_check("undecoded_read_31", 5'd31, 8'h00);
      csr_write(CTRL_A, 8'hFF);
      csr_check("ctrl_ff_read", CTRL_A, 8'h83);
      csr_write(DUTY_A, 8'hFF);
      csr_check("duty_ff_read", DUTY_A, 8'h7F);

      // Let the new settings load at the next wrap, then constant high
      pwm_ce = 1'b1;
      for (int i = 0; i < 130; i++) tick();
      chk("ff_clamp_high", {7'b0, pwm_out}, 8'h01);
      expect_pwm("ff_clamp_run", 20, 1'b1);

      // Asynchronous reset mid-period while pwm_out=1
      rst = 1'b1;
      #1;
      chk("async_reset_pwm", {7'b0, pwm_out}, 8'h00);
      csr_check("async_reset_ctrl", CTRL_A, 8'h00);
      csr_check("async_reset_duty", DUTY_A, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_pwm("post_reset_low", 10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
